dtmf_tone_sequencer: RTL and testbench

Consumes keypad digit codes and gates the matching row and column tone clocks onto the DTMF output for a fixed tone-on time, followed by a silent gap. It sits directly downstream of the eight `stepdown_*Hz` dividers: 697, 770, 852 and 941 Hz rows; 1209, 1336, 1477 and 1633 Hz columns. It sits upstream of the audio/PWM output pin. Digits are buffered, so a fast producer (NIOS PIO or keypad scanner) can queue a dial string.

---
 rtl/dtmf_pkg.sv | 46 ++++
 rtl/dtmf_tone_sequencer_if.sv | 11 +
 rtl/dtmf_digit_fifo.sv | 87 ++++++++
 rtl/dtmf_tone_sequencer.sv | 110 +++++++++++
 tb/tb_dtmf_tone_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtmf_pkg.sv
// Shared DTMF definitions: digit codes, widths, FSM state encoding and keypad decode.
package dtmf_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned MS_W    = 8;

  localparam logic [DIGIT_W-1:0] DTMF_STAR = 4'hA;
  localparam logic [DIGIT_W-1:0] DTMF_HASH = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } dtmf_state_e;

  typedef struct packed {
    logic [SEL_W-1:0] row;
    logic [SEL_W-1:0] col;
  } dtmf_sel_t;

  // Keypad layout: codes 0xC..0xF are the A..D column keys.
  function automatic dtmf_sel_t dtmf_decode(input logic [DIGIT_W-1:0] digit);
    dtmf_sel_t sel;
    case (digit)
      4'h1:      sel = '{row: 2'd0, col: 2'd0};
      4'h2:      sel = '{row: 2'd0, col: 2'd1};
      4'h3:      sel = '{row: 2'd0, col: 2'd2};
      4'h4:      sel = '{row: 2'd1, col: 2'd0};
      4'h5:      sel = '{row: 2'd1, col: 2'd1};
      4'h6:      sel = '{row: 2'd1, col: 2'd2};
      4'h7:      sel = '{row: 2'd2, col: 2'd0};
      4'h8:      sel = '{row: 2'd2, col: 2'd1};
      4'h9:      sel = '{row: 2'd2, col: 2'd2};
      DTMF_STAR: sel = '{row: 2'd3, col: 2'd0};
      DTMF_HASH: sel = '{row: 2'd3, col: 2'd2};
      4'hC:      sel = '{row: 2'd0, col: 2'd3};
      4'hD:      sel = '{row: 2'd1, col: 2'd3};
      4'hE:      sel = '{row: 2'd2, col: 2'd3};
      4'hF:      sel = '{row: 2'd3, col: 2'd3};
      default:   sel = '{row: 2'd3, col: 2'd1};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dtmf_tone_sequencer_if.sv
// Digit producer handshake into the DTMF tone sequencer.
interface dtmf_tone_sequencer_if;
  import dtmf_pkg::*;

  logic [DIGIT_W-1:0] digit_in;
  logic               digit_valid_in;
  logic               digit_ready_out;

  modport master (output digit_in, output digit_valid_in, input digit_ready_out);
  modport slave  (input digit_in, input digit_valid_in, output digit_ready_out);
endinterface

// File: rtl/dtmf_digit_fifo.sv
// Digit buffer: 4-entry FIFO when DTMF_DIGIT_FIFO_EN is defined, else one holding register.
// ready is a registered copy of !full so it is low during reset and rises on the first edge after.
module dtmf_digit_fifo
  import dtmf_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [DIGIT_W-1:0] push_data,
  input  logic               pop,
  output logic [DIGIT_W-1:0] data,
  output logic               empty,
  output logic               full,
  output logic               ready
);

  logic push_ok;
  logic pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

`ifdef DTMF_DIGIT_FIFO_EN

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;

  logic [DIGIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;

  // Simultaneous push and pop leaves occupancy unchanged.
  assign count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ready  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      empty <= (count_nxt == CNT_W'(0));
      full  <= (count_nxt == CNT_W'(DEPTH));
      ready <= (count_nxt != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign data = mem[rd_ptr];

`else

  logic [DIGIT_W-1:0] hold;
  logic               loaded_nxt;

  assign loaded_nxt = push_ok ? 1'b1 : (pop_ok ? 1'b0 : full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      ready <= 1'b0;
    end else begin
      if (push_ok) hold <= push_data;
      empty <= !loaded_nxt;
      full  <= loaded_nxt;
      ready <= !loaded_nxt;
    end
  end

  assign data = hold;

`endif

endmodule

// File: rtl/dtmf_tone_sequencer.sv
// Buffers keypad digits and gates the matching row/column tone clocks for TONE_MS, then GAP_MS of silence.
// Build option: define DTMF_DIGIT_FIFO_EN for a 4-deep digit FIFO instead of a single holding register.
module dtmf_tone_sequencer
  import dtmf_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = 1000,
  parameter int unsigned TONE_MS      = 100,
  parameter int unsigned GAP_MS       = 50
)(
  input  logic                  clk_1m_in,
  input  logic                  reset_b,
  input  logic [3:0]            row_clks_in,
  input  logic [3:0]            col_clks_in,
  dtmf_tone_sequencer_if.slave  digit_bus,
  output logic                  row_tone_out,
  output logic                  col_tone_out,
  output logic [1:0]            tone_mix_out,
  output logic                  tone_active_out
);

  localparam int unsigned PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICKS_PER_MS - 1);
  localparam logic [MS_W-1:0]  TONE_LAST = MS_W'(TONE_MS - 1);
  localparam logic [MS_W-1:0]  GAP_LAST  = MS_W'(GAP_MS - 1);

  dtmf_state_e        state;
  dtmf_sel_t          sel;
  logic [PRE_W-1:0]   pre_cnt;
  logic [MS_W-1:0]    ms_cnt;

  logic               fifo_push;
  logic               fifo_pop;
  logic [DIGIT_W-1:0] fifo_data;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_ready;

  logic               tone_on_c;
  logic               row_gate_c;
  logic               col_gate_c;
  logic [MS_W-1:0]    ms_last_c;

  assign fifo_push = digit_bus.digit_valid_in && fifo_ready && !fifo_full;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign digit_bus.digit_ready_out = fifo_ready;

  dtmf_digit_fifo u_fifo (
    .clk       (clk_1m_in),
    .rst_n     (reset_b),
    .push      (fifo_push),
    .push_data (digit_bus.digit_in),
    .pop       (fifo_pop),
    .data      (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .ready     (fifo_ready)
  );

  // Tone inputs share this clock, so they are gated directly without synchronizers.
  assign tone_on_c  = (state == TONE);
  assign row_gate_c = tone_on_c && row_clks_in[sel.row];
  assign col_gate_c = tone_on_c && col_clks_in[sel.col];
  assign ms_last_c  = tone_on_c ? TONE_LAST : GAP_LAST;

  // Sequencer: both counters clear on every state entry so each phase is exact.
  always_ff @(posedge clk_1m_in or negedge reset_b) begin
    if (!reset_b) begin
      state           <= IDLE;
      sel             <= '0;
      pre_cnt         <= '0;
      ms_cnt          <= '0;
      row_tone_out    <= 1'b0;
      col_tone_out    <= 1'b0;
      tone_mix_out    <= '0;
      tone_active_out <= 1'b0;
    end else begin
      row_tone_out    <= row_gate_c;
      col_tone_out    <= col_gate_c;
      tone_mix_out    <= 2'(row_gate_c) + 2'(col_gate_c);
      tone_active_out <= tone_on_c;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            sel     <= dtmf_decode(fifo_data);
            pre_cnt <= '0;
            ms_cnt  <= '0;
            state   <= TONE;
          end
        end
        TONE, GAP: begin
          if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            if (ms_cnt == ms_last_c) begin
              ms_cnt <= '0;
              state  <= tone_on_c ? GAP : IDLE;
            end else begin
              ms_cnt <= ms_cnt + MS_W'(1);
            end
          end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtmf_tone_sequencer.sv
// Directed bench for dtmf_tone_sequencer with shortened tone/gap timing.
module tb_dtmf_tone_sequencer;

  localparam int unsigned TPM     = 4;
  localparam int unsigned TONE_MS = 25;
  localparam int unsigned GAP_MS  = 10;
  localparam int T_CYC = 100;
  localparam int G_CYC = 40;
  localparam int P_CYC = 141;

  logic       clk      = 1'b0;
  logic       reset_b  = 1'b1;
  logic [3:0] row_clks = '0;
  logic [3:0] col_clks = '0;
  logic       row_tone;
  logic       col_tone;
  logic [1:0] tone_mix;
  logic       tone_active;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  logic [3:0] samp_row = '0;
  logic [3:0] samp_col = '0;
  int rise_edges [$];

  int exp_row [16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 0, 1, 2, 3};
  int exp_col [16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 2, 3, 3, 3, 3};

  dtmf_tone_sequencer_if dif();

  dtmf_tone_sequencer #(
    .TICKS_PER_MS (TPM),
    .TONE_MS      (TONE_MS),
    .GAP_MS       (GAP_MS)
  ) dut (
    .clk_1m_in       (clk),
    .reset_b         (reset_b),
    .row_clks_in     (row_clks),
    .col_clks_in     (col_clks),
    .digit_bus       (dif),
    .row_tone_out    (row_tone),
    .col_tone_out    (col_tone),
    .tone_mix_out    (tone_mix),
    .tone_active_out (tone_active)
  );

  always #5 clk = ~clk;

  // Distinct square waves per tone bit; samp_* hold what the DUT saw at the last edge.
  initial begin
    forever begin
      @(posedge clk);
      edge_n   = edge_n + 1;
      samp_row = row_clks;
      samp_col = col_clks;
      #1;
      row_clks = 4'(edge_n);
      col_clks = ~4'(edge_n >> 1);
    end
  end

  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tone_active === 1'b1 && !prev) rise_edges.push_back(edge_n);
      prev = (tone_active === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, edge %0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    dif.digit_valid_in = 1'b0;
    reset_b = 1'b0;
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] d, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    dif.digit_in = d;
    dif.digit_valid_in = 1'b1;
    while (dif.digit_ready_out !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    acc = (dif.digit_ready_out === 1'b1) ? edge_n + 1 : -1;
    @(negedge clk);
    dif.digit_valid_in = 1'b0;
  endtask

  task automatic measure(input int d, output int start, output int width,
                         output int bad, output int gap_bad);
    int n;
    logic er;
    logic ec;
    n = 0; start = -1; width = 0; bad = 0; gap_bad = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tone_active !== 1'b1 && n < 1000);
    if (tone_active === 1'b1) start = edge_n;
    while (tone_active === 1'b1 && width < 5000) begin
      er = samp_row[exp_row[d]];
      ec = samp_col[exp_col[d]];
      if (row_tone !== er || col_tone !== ec || tone_mix !== 2'(er) + 2'(ec)) bad++;
      width++;
      @(negedge clk);
    end
    for (int i = 0; i < G_CYC - 1; i++) begin
      if (row_tone !== 1'b0 || col_tone !== 1'b0 || tone_mix !== 2'd0 || tone_active !== 1'b0)
        gap_bad++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_b = 1'b0;
    dif.digit_valid_in = 1'b0;
    dif.digit_in = '0;
    repeat (2) @(negedge clk);
    checks++; if (dif.digit_ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", dif.digit_ready_out); end
    checks++; if (row_tone !== 1'b0) begin errors++; $display("FAIL reset_row: got %b expected 0", row_tone); end
    checks++; if (col_tone !== 1'b0) begin errors++; $display("FAIL reset_col: got %b expected 0", col_tone); end
    checks++; if (tone_mix !== 2'd0) begin errors++; $display("FAIL reset_mix: got %0d expected 0", tone_mix); end
    checks++; if (tone_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", tone_active); end
    reset_b = 1'b1;
    @(negedge clk);
    checks++; if (dif.digit_ready_out !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", dif.digit_ready_out); end
    checks++; if (tone_active !== 1'b0) begin errors++; $display("FAIL release_active: got %b expected 0", tone_active); end
  endtask

  task automatic test_single_digit();
    int acc, start, width, bad, gbad;
    do_reset();
    push(4'h5, acc);
    measure(5, start, width, bad, gbad);
    checks++; if (start !== acc + 2) begin errors++; $display("FAIL single_latency: got %0d expected %0d", start, acc + 2); end
    checks++; if (width !== T_CYC) begin errors++; $display("FAIL single_width: got %0d expected %0d", width, T_CYC); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_tone: got %0d bad cycles expected 0", bad); end
    checks++; if (gbad !== 0) begin errors++; $display("FAIL single_gap: got %0d bad cycles expected 0", gbad); end
  endtask

  task automatic test_full_map();
    int acc, start, width, bad, gbad;
    do_reset();
    for (int d = 0; d < 16; d++) begin
      push(4'(d), acc);
      measure(d, start, width, bad, gbad);
      checks++; if (width !== T_CYC) begin errors++; $display("FAIL map_width digit %0d: got %0d expected %0d", d, width, T_CYC); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL map_tone digit %0d: got %0d bad cycles expected 0", d, bad); end
      checks++; if (gbad !== 0) begin errors++; $display("FAIL map_gap digit %0d: got %0d bad cycles expected 0", d, gbad); end
    end
  endtask

  task automatic test_buffering();
    int acc [6];
    int n;
    logic rdy5;
    do_reset();
    rdy5 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      dif.digit_in = 4'(i + 1);
      dif.digit_valid_in = 1'b1;
      if (i == 5) rdy5 = dif.digit_ready_out;
      n = 0;
      while (dif.digit_ready_out !== 1'b1 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      acc[i] = (dif.digit_ready_out === 1'b1) ? edge_n + 1 : -1;
      @(negedge clk);
    end
    dif.digit_valid_in = 1'b0;
    checks++; if (rdy5 !== 1'b0) begin errors++; $display("FAIL buf_ready_drop: got %b expected 0", rdy5); end
`ifdef DTMF_DIGIT_FIFO_EN
    for (int i = 1; i < 5; i++) begin
      checks++; if (acc[i] !== acc[0] + i) begin errors++; $display("FAIL buf_accept %0d: got %0d expected %0d", i, acc[i], acc[0] + i); end
    end
    checks++; if (acc[5] !== acc[0] + P_CYC + 2) begin errors++; $display("FAIL buf_stall: got %0d expected %0d", acc[5], acc[0] + P_CYC + 2); end
`else
    checks++; if (acc[1] !== acc[0] + 2) begin errors++; $display("FAIL buf_second: got %0d expected %0d", acc[1], acc[0] + 2); end
    checks++; if (acc[2] !== acc[0] + 2 + P_CYC) begin errors++; $display("FAIL buf_third: got %0d expected %0d", acc[2], acc[0] + 2 + P_CYC); end
    checks++; if (acc[5] !== acc[0] + 2 + 4 * P_CYC) begin errors++; $display("FAIL buf_sixth: got %0d expected %0d", acc[5], acc[0] + 2 + 4 * P_CYC); end
`endif
  endtask

  task automatic test_reset_mid_tone();
    int a, b, c, n, rises;
    do_reset();
    push(4'hB, a);
    push(4'h3, b);
`ifdef DTMF_DIGIT_FIFO_EN
    push(4'h7, c);
`endif
    n = 0;
    while (edge_n < a + 32 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (tone_active !== 1'b1) begin errors++; $display("FAIL mid_active_before: got %b expected 1", tone_active); end
    reset_b = 1'b0;
    #1;
    checks++; if ({row_tone, col_tone, tone_mix, tone_active} !== 5'b0) begin errors++; $display("FAIL mid_outputs: got %b expected 00000", {row_tone, col_tone, tone_mix, tone_active}); end
    checks++; if (dif.digit_ready_out !== 1'b0) begin errors++; $display("FAIL mid_ready_low: got %b expected 0", dif.digit_ready_out); end
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    checks++; if (dif.digit_ready_out !== 1'b1) begin errors++; $display("FAIL mid_ready_release: got %b expected 1", dif.digit_ready_out); end
    rises = 0;
    for (int i = 0; i < T_CYC + G_CYC + 20; i++) begin
      if (tone_active !== 1'b0) rises++;
      @(negedge clk);
    end
    checks++; if (rises !== 0) begin errors++; $display("FAIL mid_queue_flushed: got %0d active cycles expected 0", rises); end
  endtask

  task automatic test_back_to_back();
    int a, b, n, s0, s1;
    do_reset();
    rise_edges.delete();
    push(4'h9, a);
    push(4'hF, b);
    n = 0;
    while (rise_edges.size() < 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    s0 = (rise_edges.size() > 0) ? rise_edges[0] : -1;
    s1 = (rise_edges.size() > 1) ? rise_edges[1] : -1;
`ifdef DTMF_DIGIT_FIFO_EN
    checks++; if (b !== a + 1) begin errors++; $display("FAIL b2b_accept: got %0d expected %0d", b, a + 1); end
`else
    checks++; if (b !== a + 2) begin errors++; $display("FAIL b2b_accept: got %0d expected %0d", b, a + 2); end
`endif
    checks++; if (s0 !== a + 2) begin errors++; $display("FAIL b2b_first_start: got %0d expected %0d", s0, a + 2); end
    checks++; if (s1 - s0 !== P_CYC) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", s1 - s0, P_CYC); end
  endtask

  initial begin
    dif.digit_in = '0;
    dif.digit_valid_in = 1'b0;
    test_reset();
    test_single_digit();
    test_full_map();
    test_buffering();
    test_reset_mid_tone();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
